// File: rtl/uxa_ps2_fifo_ctrl_if.sv
// ============================================================================
// Module   : uxa_ps2_fifo_ctrl_if
// Brief    : Host read port (stb/ack handshake plus data-available flag)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface uxa_ps2_fifo_ctrl_if;
  logic       stb_i;
  logic       ack_o;
  logic [7:0] dat_o;
  logic       avail_o;

  modport slave  (input  stb_i, output ack_o, output dat_o, output avail_o);
  modport master (output stb_i, input  ack_o, input  dat_o, input  avail_o);
endinterface

`default_nettype wire

// File: rtl/uxa_ps2_fifo_ctrl.sv
// ============================================================================
// Module   : uxa_ps2_fifo_ctrl
// Brief    : Sequences PS/2 bytes into the byte FIFO and serves host reads
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uxa_ps2_fifo_ctrl #(
  parameter int CNT_W   = 8,
  parameter bit HOLD_EN = 1'b1
) (
  input  wire logic             sys_clk_i,
  input  wire logic             sys_reset_i,
  input  wire logic [7:0]       rx_data_i,
  input  wire logic             rx_strobe_i,
  uxa_ps2_fifo_ctrl_if.slave    host,
  output logic                  overflow_o,
  input  wire logic             clr_ovf_i,
  output logic [CNT_W-1:0]      drop_cnt_o,
  output logic [7:0]            fifo_d_o,
  output logic                  fifo_we_o,
  output logic                  fifo_wp_inc_o,
  output logic                  fifo_rp_inc_o,
  input  wire logic [7:0]       fifo_q_i,
  input  wire logic             fifo_full_i,
  input  wire logic             fifo_data_available_i
);

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_WRITE  = 2'd1,
    W_BUMP   = 2'd2,
    W_SETTLE = 2'd3
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_ACK    = 2'd1,
    R_SETTLE = 2'd2
  } r_state_t;

  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  w_state_t         r_w_state, w_w_next;
  r_state_t         r_r_state, w_r_next;
  logic [7:0]       r_fifo_d, r_hold_data, r_dat, w_d_next;
  logic             r_hold_vld, r_avail, r_ovf;
  logic [CNT_W-1:0] r_drop_cnt;
  logic             w_load_d, w_hold_take, w_hold_cap, w_drop;
  logic             w_we, w_wp_inc, w_rd_take, w_ack;

  // Write sequencer: idle decides accept/drop; busy states only route strobes
  always_comb begin
    w_w_next    = r_w_state;
    w_load_d    = 1'b0;
    w_d_next    = rx_data_i;
    w_hold_take = 1'b0;
    w_hold_cap  = 1'b0;
    w_drop      = 1'b0;
    w_we        = 1'b0;
    w_wp_inc    = 1'b0;
    case (r_w_state)
      W_IDLE: begin
        if (r_hold_vld) begin
          w_d_next    = r_hold_data;
          w_hold_take = 1'b1;
          w_hold_cap  = rx_strobe_i;
        end
        if (r_hold_vld || rx_strobe_i) begin
          if (fifo_full_i) begin
            w_drop = 1'b1;
          end else begin
            w_load_d = 1'b1;
            w_w_next = W_WRITE;
          end
        end
      end
      W_WRITE: begin
        w_we     = 1'b1;
        w_w_next = W_BUMP;
      end
      W_BUMP: begin
        w_wp_inc = 1'b1;
        w_w_next = W_SETTLE;
      end
      W_SETTLE: w_w_next = W_IDLE;
      default:  w_w_next = W_IDLE;
    endcase
    if (r_w_state != W_IDLE) begin
      w_hold_cap = rx_strobe_i & HOLD_EN & ~r_hold_vld;
      w_drop     = rx_strobe_i & ~w_hold_cap;
    end
  end

  always_comb begin
    w_r_next  = r_r_state;
    w_rd_take = 1'b0;
    w_ack     = 1'b0;
    case (r_r_state)
      R_IDLE: begin
        if (host.stb_i && fifo_data_available_i) begin
          w_rd_take = 1'b1;
          w_r_next  = R_ACK;
        end
      end
      R_ACK: begin
        w_ack    = 1'b1;
        w_r_next = R_SETTLE;
      end
      R_SETTLE: w_r_next = R_IDLE;
      default:  w_r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (!sys_reset_i) begin
      r_w_state   <= W_IDLE;
      r_r_state   <= R_IDLE;
      r_fifo_d    <= 8'h00;
      r_hold_data <= 8'h00;
      r_hold_vld  <= 1'b0;
      r_dat       <= 8'h00;
      r_avail     <= 1'b0;
      r_ovf       <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      r_w_state <= w_w_next;
      r_r_state <= w_r_next;
      r_avail   <= fifo_data_available_i;
      if (w_load_d) begin
        r_fifo_d <= w_d_next;
      end
      if (w_hold_cap) begin
        r_hold_vld  <= 1'b1;
        r_hold_data <= rx_data_i;
      end else if (w_hold_take) begin
        r_hold_vld <= 1'b0;
      end
      if (w_rd_take) begin
        r_dat <= fifo_q_i;
      end
      // A clear in the same cycle as a drop wins and that drop is lost
      if (clr_ovf_i) begin
        r_ovf      <= 1'b0;
        r_drop_cnt <= '0;
      end else if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drop_cnt != c_CNT_MAX) begin
          r_drop_cnt <= r_drop_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign fifo_d_o      = r_fifo_d;
  assign fifo_we_o     = w_we;
  assign fifo_wp_inc_o = w_wp_inc;
  assign fifo_rp_inc_o = w_ack;
  assign overflow_o    = r_ovf;
  assign drop_cnt_o    = r_drop_cnt;
  assign host.ack_o    = w_ack;
  assign host.dat_o    = r_dat;
  assign host.avail_o  = r_avail;

endmodule

`default_nettype wire

// File: doc/uxa_ps2_fifo_ctrl.md
Name: uxa_ps2_fifo_ctrl

Overview:
Sequencing controller between the PS/2 receive shifter, the 16-entry PS/2 byte FIFO (15 usable entries) and the host read port. It converts one-cycle "byte received" strobes into the FIFO's two-phase write protocol: write the data, then advance the write pointer. It serves host read requests with a stb/ack handshake and advances the FIFO read pointer. It drops bytes when the FIFO is full, and counts and flags those drops.

Parameters:
CNT_W, 8, width of saturating dropped-byte counter
HOLD_EN, 1, 1 = one-byte holding register absorbs a strobe arriving while a write sequence is in progress; 0 = such strobes are dropped

Ports:
sys_clk_i  in  1  system clock; all logic on rising edge
sys_reset_i  in  1  synchronous, active-low reset
rx_data_i  in  8  received byte from PS/2 shifter
rx_strobe_i  in  1  one-cycle pulse: rx_data_i valid
stb_i  in  1  host read request; held until ack_o
ack_o  out  1  one-cycle read acknowledge
dat_o  out  8  read data; valid while ack_o=1 and held until next ack
avail_o  out  1  registered copy of fifo_data_available_i
overflow_o  out  1  sticky: at least one byte dropped
clr_ovf_i  in  1  clears overflow_o and drop_cnt_o
drop_cnt_o  out  CNT_W  saturating dropped-byte count
fifo_d_o  out  8  to FIFO d_i
fifo_we_o  out  1  to FIFO we_i
fifo_wp_inc_o  out  1  to FIFO wp_inc_i
fifo_rp_inc_o  out  1  to FIFO rp_inc_i
fifo_q_i  in  8  from FIFO q_o (entry at read pointer)
fifo_full_i  in  1  from FIFO full_o
fifo_data_available_i  in  1  from FIFO data_available_o

Behaviour:
- Reset (sys_reset_i=0 at clock edge) forces every output and all state to 0: FSMs to idle, holding register empty. This applies mid-sequence: a write that has asserted fifo_we_o but not fifo_wp_inc_o is abandoned, so the FIFO pointer does not advance.
- FIFO flags are valid only one cycle after a pointer pulse. Both FSMs therefore include a SETTLE state before sampling flags again.
- Write FSM states: W_IDLE -> W_WRITE -> W_BUMP -> W_SETTLE -> W_IDLE.
  - W_IDLE: a byte is pending when rx_strobe_i=1 or the holding register is full; the holding register has priority.
    - If pending and fifo_full_i=0: latch the byte into fifo_d_o and go to W_WRITE.
    - If pending and fifo_full_i=1: drop the byte, set overflow_o, increment drop_cnt_o, stay in W_IDLE.
  - W_WRITE: fifo_we_o=1 for exactly one cycle.
  - W_BUMP: fifo_wp_inc_o=1 for exactly one cycle.
  - W_SETTLE: all FIFO strobes low.
  - Latency: strobe at cycle N -> we at N+1 -> wp_inc at N+2 -> idle at N+4. Peak rate is one byte per 4 cycles.
- Strobe outside W_IDLE:
  - HOLD_EN=1 and holding register empty: capture the byte.
  - Otherwise: drop it and count it.
  - A strobe arriving in W_IDLE while the holding register is full is captured into the holding register as the held byte drains.
- fifo_d_o is stable from W_WRITE through W_SETTLE.
- Read FSM states: R_IDLE -> R_ACK -> R_SETTLE -> R_IDLE.
  - R_IDLE: stb_i=1 and fifo_data_available_i=1 -> dat_o<=fifo_q_i, go to R_ACK.
  - R_IDLE: stb_i=1 with no data available -> wait; no ack, no timeout.
  - R_ACK: ack_o=1 and fifo_rp_inc_o=1 for one cycle.
  - R_SETTLE: ack_o=0. The host must drop stb_i in this cycle; stb_i still high in R_IDLE starts a new read.
  - Read latency: 1 cycle from accepted stb_i to ack_o.
- Read and write FSMs are independent; simultaneous wp_inc and rp_inc pulses are legal.
- drop_cnt_o saturates at 2^CNT_W-1; overflow_o stays set at saturation.
- clr_ovf_i has priority over a drop in the same cycle: the result is 0/0 and that drop is not counted.
- avail_o lags fifo_data_available_i by one cycle.

Test Plan:
- Reset: drive arbitrary inputs, hold sys_reset_i=0 for 2 cycles -> every output 0. Release -> ack_o=0, overflow_o=0, drop_cnt_o=0.
- Single byte: rx_strobe_i with 0xB7 at N -> fifo_we_o=1 only at N+1, fifo_wp_inc_o=1 only at N+2, fifo_d_o=0xB7. Then stb_i -> ack_o one cycle with dat_o=0xB7 and one fifo_rp_inc_o pulse. avail_o ends 0.
- Back-to-back: strobes 0x01 and 0x02 one cycle apart (HOLD_EN=1) -> two complete write sequences in order, drop_cnt_o=0. A third strobe during the first sequence -> drop_cnt_o=1, overflow_o=1.
- Overflow: write 20 bytes 1..20 spaced 5 cycles -> bytes 16..20 dropped, drop_cnt_o=5, overflow_o=1. 15 reads return 1..15 in order, then avail_o=0. clr_ovf_i -> both cleared.
- Blocking read: stb_i held on an empty FIFO for 10 cycles -> no ack_o, no fifo_rp_inc_o. Strobe 0x5A -> ack_o exactly 1 cycle after flags settle, dat_o=0x5A.
- Reset mid-write: assert reset in the W_WRITE cycle -> fifo_wp_inc_o never pulses, FIFO flags unchanged, FSM idle after release.
